// File: rtl/golomb_rice_decode_if.sv
// rtl/golomb_rice_decode_if.sv - Golomb-Rice decoder control, bitstream and result signals
interface golomb_rice_decode_if;
    logic       start;
    logic [3:0] k;
    logic [6:0] B_Q;
    logic [6:0] N_Q;
    logic       bit_in;
    logic       bit_valid;
    logic       bit_ready;
    logic       busy;
    logic       done;
    logic [8:0] MErrval;
    logic [8:0] Errval;
    logic       err;

    modport master (
        output start, k, B_Q, N_Q, bit_in, bit_valid,
        input  bit_ready, busy, done, MErrval, Errval, err
    );

    modport slave (
        input  start, k, B_Q, N_Q, bit_in, bit_valid,
        output bit_ready, busy, done, MErrval, Errval, err
    );
endinterface

// File: rtl/golomb_rice_decode.sv
// rtl/golomb_rice_decode.sv - Golomb-Rice code-word decoder with inverse error mapping
// Serial MSB-first bitstream in, mapped MErrval and signed Errval out, one code word per start.
module golomb_rice_decode #(
    parameter int QBPP  = 8,
    parameter int LIMIT = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    golomb_rice_decode_if.slave  dec
);
    localparam int         ESC    = LIMIT - QBPP - 1;
    localparam logic [4:0] ESC_Q  = 5'(ESC);
    localparam logic [4:0] QBPP_C = 5'(QBPP);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_PREFIX = 3'd1;
    localparam logic [2:0] S_SUFFIX = 3'd2;
    localparam logic [2:0] S_ESCAPE = 3'd3;
    localparam logic [2:0] S_MAP    = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [3:0]  k_q, k_d;
    logic [6:0]  bq_q, bq_d;
    logic [6:0]  nq_q, nq_d;
    logic [4:0]  q_q, q_d;
    logic [15:0] r_q, r_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        esc_q, esc_d;
    logic        err_q, err_d;
    logic [8:0]  merr_q, merr_d;
    logic [8:0]  errval_q, errval_d;

    logic        bit_ready;
    logic        bit_take;
    logic        in_map;

    logic [31:0] v_norm;
    logic [31:0] v_val;
    logic        v_ovf;
    logic [8:0]  v9;
    logic [8:0]  half;
    logic signed [8:0] bq2;
    logic signed [8:0] nq_neg;
    logic        special;
    logic        err_map;
    logic [8:0]  merr_map;
    logic [8:0]  errval_map;

    assign bit_ready = (state_q == S_PREFIX) || (state_q == S_SUFFIX) || (state_q == S_ESCAPE);
    assign bit_take  = bit_ready && dec.bit_valid;
    assign in_map    = (state_q == S_MAP);

    // Value reconstruction; the escape field carries MErrval-1.
    assign v_norm = (32'(q_q) << k_q) | 32'(r_q);
    assign v_val  = esc_q ? (32'(r_q) + 32'd1) : v_norm;
    assign v_ovf  = v_val > 32'd511;
    assign v9     = v_val[8:0];
    assign half   = {1'b0, v9[8:1]};

    // Special map when k==0 and 2*B_Q <= -N_Q, compared as 9-bit signed values.
    assign bq2     = {bq_q[6], bq_q, 1'b0};
    assign nq_neg  = -$signed({2'b00, nq_q});
    assign special = (k_q == 4'd0) && (bq2 <= nq_neg);

    // Both maps reduce to V>>1 or its ones' complement (-(V>>1)-1), chosen by parity.
    assign err_map    = err_q | v_ovf;
    assign merr_map   = err_map ? 9'd0 : v9;
    assign errval_map = err_map ? 9'd0 : ((v9[0] ^ special) ? ~half : half);

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        bq_d     = bq_q;
        nq_d     = nq_q;
        q_d      = q_q;
        r_d      = r_q;
        cnt_d    = cnt_q;
        esc_d    = esc_q;
        err_d    = err_q;
        merr_d   = merr_q;
        errval_d = errval_q;

        case (state_q)
            S_IDLE: begin
                if (dec.start) begin
                    state_d = S_PREFIX;
                    k_d     = dec.k;
                    bq_d    = dec.B_Q;
                    nq_d    = dec.N_Q;
                    q_d     = 5'd0;
                    r_d     = 16'd0;
                    cnt_d   = 5'd0;
                    esc_d   = 1'b0;
                    err_d   = 1'b0;
                end
            end
            S_PREFIX: begin
                if (bit_take) begin
                    if (!dec.bit_in) begin
                        if (q_q == ESC_Q) begin
                            err_d   = 1'b1;
                            state_d = S_MAP;
                        end else begin
                            q_d = q_q + 5'd1;
                        end
                    end else if (q_q == ESC_Q) begin
                        state_d = S_ESCAPE;
                        cnt_d   = QBPP_C;
                        esc_d   = 1'b1;
                    end else if (k_q == 4'd0) begin
                        state_d = S_MAP;
                    end else begin
                        state_d = S_SUFFIX;
                        cnt_d   = {1'b0, k_q};
                    end
                end
            end
            S_SUFFIX, S_ESCAPE: begin
                if (bit_take) begin
                    r_d   = {r_q[14:0], dec.bit_in};
                    cnt_d = cnt_q - 5'd1;
                    if (cnt_q == 5'd1) begin
                        state_d = S_MAP;
                    end
                end
            end
            S_MAP: begin
                state_d  = S_IDLE;
                err_d    = err_map;
                merr_d   = merr_map;
                errval_d = errval_map;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            k_q      <= 4'd0;
            bq_q     <= 7'd0;
            nq_q     <= 7'd0;
            q_q      <= 5'd0;
            r_q      <= 16'd0;
            cnt_q    <= 5'd0;
            esc_q    <= 1'b0;
            err_q    <= 1'b0;
            merr_q   <= 9'd0;
            errval_q <= 9'd0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            bq_q     <= bq_d;
            nq_q     <= nq_d;
            q_q      <= q_d;
            r_q      <= r_d;
            cnt_q    <= cnt_d;
            esc_q    <= esc_d;
            err_q    <= err_d;
            merr_q   <= merr_d;
            errval_q <= errval_d;
        end
    end

    // Results are visible during the MAP cycle alongside done, then held from the registers.
    assign dec.bit_ready = bit_ready;
    assign dec.busy      = (state_q != S_IDLE);
    assign dec.done      = in_map;
    assign dec.MErrval   = in_map ? merr_map   : merr_q;
    assign dec.Errval    = in_map ? errval_map : errval_q;
    assign dec.err       = in_map ? err_map    : err_q;
endmodule

// File: tb/tb_golomb_rice_decode.sv
// tb/tb_golomb_rice_decode.sv - self-checking bench for golomb_rice_decode
module tb_golomb_rice_decode;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    golomb_rice_decode_if dif();
    golomb_rice_decode dut (.clk(clk), .reset(reset), .dec(dif.slave));

    int tests_run = 0;
    int tests_failed = 0;

    bit cur_bits[$];
    int exp_merr, exp_errv, exp_err, exp_nb;
    int obs_cycles, obs_merr, obs_errv, obs_err;
    bit obs_done, obs_after_done, obs_after_busy;
    int obs_after_merr;

    task automatic push_bits(input int n, input int val);
        for (int i = n - 1; i >= 0; i--) cur_bits.push_back(bit'((val >> i) & 1));
    endtask

    task automatic push_zeros(input int n);
        for (int i = 0; i < n; i++) cur_bits.push_back(1'b0);
    endtask

    // Reference: parse the code word straight from the bit list with integer arithmetic.
    task automatic model(input int k, input int bq, input int nq);
        int q;
        int idx;
        int v;
        int fld;
        bit special;
        q = 0; idx = 0; v = 0; fld = 0;
        exp_err = 0;
        while (idx < cur_bits.size() && cur_bits[idx] == 1'b0 && q < 24) begin
            q++; idx++;
        end
        if (q == 24) begin
            exp_err = 1;
        end else begin
            idx++;
            if (q == 23) begin
                for (int i = 0; i < 8; i++) begin fld = fld * 2 + int'(cur_bits[idx]); idx++; end
                v = fld + 1;
            end else begin
                for (int i = 0; i < k; i++) begin fld = fld * 2 + int'(cur_bits[idx]); idx++; end
                v = q * (1 << k) + fld;
            end
            if (v > 511) exp_err = 1;
        end
        exp_nb = idx;
        special = (k == 0) && (2 * bq <= -nq);
        if (exp_err != 0) begin
            exp_merr = 0; exp_errv = 0;
        end else begin
            exp_merr = v;
            if (!special) exp_errv = (v % 2 == 0) ? v / 2 : -(v + 1) / 2;
            else          exp_errv = (v % 2 == 1) ? (v - 1) / 2 : -(v / 2) - 1;
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after done.
    // stall: 0 none, 1 toggle bit_valid, 2 random gaps.  obs_cycles excludes stall cycles.
    task automatic run_decode(input int k, input int bq, input int nq, input int stall,
                              input bit poke_mid, input bit poke_done);
        int idx;
        int stalls;
        int cyc;
        bit seen;
        bit gap;
        idx = 0; stalls = 0; cyc = 0; seen = 0;
        dif.k = 4'(k); dif.B_Q = 7'(bq); dif.N_Q = 7'(nq);
        dif.start = 1'b1; dif.bit_valid = 1'b0;
        @(negedge clk);
        dif.start = 1'b0;
        cyc = 1;
        while (!seen && cyc < 200) begin
            if (dif.done) begin
                seen = 1;
            end else begin
                gap = (stall == 1) ? bit'(cyc % 2) : (stall == 2) ? bit'($urandom_range(0, 1)) : 1'b0;
                if (idx < exp_nb && !gap) begin
                    dif.bit_valid = 1'b1; dif.bit_in = cur_bits[idx];
                end else begin
                    dif.bit_valid = 1'b0; dif.bit_in = 1'($urandom_range(0, 1));
                    if (idx < exp_nb) stalls++;
                end
                if (poke_mid && cyc == 2) begin
                    dif.start = 1'b1; dif.k = 4'($urandom_range(0, 15));
                end
                @(posedge clk);
                if (dif.bit_valid) idx++;
                @(negedge clk);
                dif.start = 1'b0; dif.bit_valid = 1'b0;
                cyc++;
            end
        end
        obs_done   = seen;
        obs_cycles = cyc - stalls;
        obs_merr   = int'(dif.MErrval);
        obs_errv   = int'($signed(dif.Errval));
        obs_err    = int'(dif.err);
        if (poke_done) begin dif.start = 1'b1; dif.k = 4'd7; end
        @(negedge clk);
        dif.start = 1'b0;
        obs_after_done = dif.done;
        obs_after_busy = dif.busy;
        obs_after_merr = int'(dif.MErrval);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        dif.start = 1'b0; dif.k = 4'd0; dif.B_Q = 7'd0; dif.N_Q = 7'd0;
        dif.bit_in = 1'b0; dif.bit_valid = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({dif.bit_ready, dif.busy, dif.done, dif.err, dif.MErrval, dif.Errval} !== 22'd0) begin
            tests_failed++;
            $display("FAIL reset_state: got rdy=%0b busy=%0b done=%0b err=%0b M=%0d E=%0d, want all 0",
                     dif.bit_ready, dif.busy, dif.done, dif.err, dif.MErrval, dif.Errval);
        end
        reset = 1'b1;
        @(negedge clk);
        tests_run++;
        if (dif.busy !== 1'b0) begin
            tests_failed++; $display("FAIL idle_busy: got %0b, want 0", dif.busy);
        end
    endtask

    task automatic test_basic();
        cur_bits.delete(); push_bits(6, 6'b000110);
        model(2, 0, 1);
        run_decode(2, 0, 1, 0, 0, 0);
        tests_run++;
        if (!obs_done || obs_cycles != 7) begin
            tests_failed++; $display("FAIL basic_latency: done=%0b cycles=%0d, want done at cycle 7", obs_done, obs_cycles);
        end
        tests_run++;
        if (obs_merr != 14 || obs_errv != 7 || obs_err != 0) begin
            tests_failed++; $display("FAIL basic_value: got M=%0d E=%0d err=%0d, want 14 7 0", obs_merr, obs_errv, obs_err);
        end
        tests_run++;
        if (obs_after_done !== 1'b0 || obs_after_busy !== 1'b0 || obs_after_merr != 14) begin
            tests_failed++;
            $display("FAIL basic_after: done=%0b busy=%0b M=%0d, want 0 0 14", obs_after_done, obs_after_busy, obs_after_merr);
        end
    endtask

    task automatic test_special();
        int bqs[2];
        int want[2];
        bqs[0] = -5; want[0] = -3;
        bqs[1] = 0;  want[1] = 2;
        for (int i = 0; i < 2; i++) begin
            cur_bits.delete(); push_bits(5, 5'b00001);
            model(0, bqs[i], 8);
            run_decode(0, bqs[i], 8, 0, 0, 0);
            tests_run++;
            if (obs_merr != 4 || obs_errv != want[i] || obs_err != 0 || obs_cycles != 6) begin
                tests_failed++;
                $display("FAIL special_map bq=%0d: got M=%0d E=%0d err=%0d cyc=%0d, want 4 %0d 0 6",
                         bqs[i], obs_merr, obs_errv, obs_err, obs_cycles, want[i]);
            end
        end
    endtask

    task automatic test_escape();
        cur_bits.delete(); push_zeros(23); cur_bits.push_back(1'b1); push_bits(8, 8'hC7);
        model(3, 0, 1);
        run_decode(3, 0, 1, 0, 0, 0);
        tests_run++;
        if (obs_merr != 200 || obs_errv != 100 || obs_err != 0 || obs_cycles != 33) begin
            tests_failed++;
            $display("FAIL escape: got M=%0d E=%0d err=%0d cyc=%0d, want 200 100 0 33", obs_merr, obs_errv, obs_err, obs_cycles);
        end
    endtask

    task automatic test_error();
        cur_bits.delete(); push_zeros(22); cur_bits.push_back(1'b1); push_zeros(5);
        model(5, 0, 1);
        run_decode(5, 0, 1, 0, 0, 0);
        tests_run++;
        if (obs_err != 1 || obs_merr != 0 || obs_errv != 0 || obs_cycles != 29) begin
            tests_failed++;
            $display("FAIL overflow: got err=%0d M=%0d E=%0d cyc=%0d, want 1 0 0 29", obs_err, obs_merr, obs_errv, obs_cycles);
        end
        cur_bits.delete(); push_zeros(24);
        model(2, 0, 1);
        run_decode(2, 0, 1, 0, 0, 0);
        tests_run++;
        if (obs_err != 1 || obs_merr != 0 || obs_errv != 0 || obs_cycles != 25) begin
            tests_failed++;
            $display("FAIL too_many_zeros: got err=%0d M=%0d E=%0d cyc=%0d, want 1 0 0 25", obs_err, obs_merr, obs_errv, obs_cycles);
        end
    endtask

    task automatic test_stall();
        cur_bits.delete(); push_bits(2, 2'b11);
        model(1, 0, 1);
        run_decode(1, 0, 1, 1, 1, 0);
        tests_run++;
        if (!obs_done || obs_merr != 1 || obs_errv != -1 || obs_err != 0 || obs_cycles != 3) begin
            tests_failed++;
            $display("FAIL stall: done=%0b M=%0d E=%0d err=%0d cyc=%0d, want 1 1 -1 0 3",
                     obs_done, obs_merr, obs_errv, obs_err, obs_cycles);
        end
    endtask

    task automatic test_reset_mid();
        dif.k = 4'd0; dif.B_Q = 7'd0; dif.N_Q = 7'd1; dif.start = 1'b1;
        @(negedge clk);
        dif.start = 1'b0; dif.bit_valid = 1'b1; dif.bit_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        dif.bit_valid = 1'b0;
        reset = 1'b0;
        #1;
        tests_run++;
        if ({dif.bit_ready, dif.busy, dif.done, dif.err, dif.MErrval, dif.Errval} !== 22'd0) begin
            tests_failed++;
            $display("FAIL reset_mid: got rdy=%0b busy=%0b done=%0b err=%0b M=%0d E=%0d, want all 0",
                     dif.bit_ready, dif.busy, dif.done, dif.err, dif.MErrval, dif.Errval);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        cur_bits.delete(); cur_bits.push_back(1'b1);
        model(0, 0, 1);
        run_decode(0, 0, 1, 0, 0, 0);
        tests_run++;
        if (!obs_done || obs_merr != 0 || obs_errv != 0 || obs_err != 0 || obs_cycles != 2) begin
            tests_failed++;
            $display("FAIL after_reset: done=%0b M=%0d E=%0d err=%0d cyc=%0d, want 1 0 0 0 2",
                     obs_done, obs_merr, obs_errv, obs_err, obs_cycles);
        end
    endtask

    task automatic test_back_to_back();
        cur_bits.delete(); push_bits(4, 4'b0110);
        model(2, 3, 4);
        run_decode(2, 3, 4, 0, 0, 1);
        tests_run++;
        if (obs_after_busy !== 1'b0 || obs_merr != exp_merr) begin
            tests_failed++;
            $display("FAIL b2b_first: busy=%0b M=%0d, want busy 0 M=%0d", obs_after_busy, obs_merr, exp_merr);
        end
        cur_bits.delete(); push_bits(3, 3'b101);
        model(2, 3, 4);
        run_decode(2, 3, 4, 0, 0, 0);
        tests_run++;
        if (obs_merr != exp_merr || obs_errv != exp_errv || obs_cycles != exp_nb + 1) begin
            tests_failed++;
            $display("FAIL b2b_second: M=%0d E=%0d cyc=%0d, want %0d %0d %0d",
                     obs_merr, obs_errv, obs_cycles, exp_merr, exp_errv, exp_nb + 1);
        end
    endtask

    task automatic test_random();
        int k, bq, nq, mode, q;
        for (int it = 0; it < 40; it++) begin
            k    = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 15);
            bq   = $urandom_range(0, 127) - 64;
            nq   = $urandom_range(0, 127);
            mode = $urandom_range(0, 9);
            cur_bits.delete();
            if (mode == 0) begin
                push_zeros(24);
            end else if (mode <= 2) begin
                push_zeros(23); cur_bits.push_back(1'b1); push_bits(8, $urandom_range(0, 255));
            end else begin
                q = (k > 4) ? $urandom_range(0, 6) : $urandom_range(0, 22);
                push_zeros(q); cur_bits.push_back(1'b1);
                for (int i = 0; i < k; i++) cur_bits.push_back(1'($urandom_range(0, 1)));
            end
            model(k, bq, nq);
            run_decode(k, bq, nq, 2, 0, 0);
            tests_run++;
            if (!obs_done || obs_merr != exp_merr || obs_errv != exp_errv || obs_err != exp_err || obs_cycles != exp_nb + 1) begin
                tests_failed++;
                $display("FAIL random[%0d] k=%0d bq=%0d nq=%0d: got done=%0b M=%0d E=%0d err=%0d cyc=%0d, want M=%0d E=%0d err=%0d cyc=%0d",
                         it, k, bq, nq, obs_done, obs_merr, obs_errv, obs_err, obs_cycles,
                         exp_merr, exp_errv, exp_err, exp_nb + 1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_special();
        test_escape();
        test_error();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
